// File: rtl/suprloco_ioctl_pkg.sv
// Shared constants and types for the ioctl download/upload path.
package suprloco_ioctl_pkg;

    // Upload responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_LAT     = 2'd2,
        ST_CAPTURE = 2'd3
    } upload_state_e;

    // ioctl_index values understood by the core.
    localparam logic [15:0] IOCTL_IDX_ROM   = 16'd0;
    localparam logic [15:0] IOCTL_IDX_NVRAM = 16'd4;
    localparam logic [15:0] IOCTL_IDX_DIPSW = 16'd254;

    // Number of valid bytes in the game-board ROM/BRAM image.
    localparam logic [16:0] ROM_END = 17'h1A620;

    // Width of the HPS byte address bus.
    localparam int IOCTL_ADDR_W = 27;

endpackage

// File: rtl/suprloco_ioctl_upload.sv
// ioctl upload responder: serves HPS read strobes from a synchronous BRAM
// read port or from the DIP switch banks, stalling the HPS with ioctl_wait
// while a BRAM fetch is in flight.
module suprloco_ioctl_upload
    import suprloco_ioctl_pkg::*;
#(
    parameter int          AW          = 17,
    parameter int unsigned MEM_SIZE    = 32'(ROM_END),
    parameter int          RD_LAT      = 1,
    parameter logic [15:0] UPLD_INDEX  = IOCTL_IDX_ROM,
    parameter logic [15:0] DIPSW_INDEX = IOCTL_IDX_DIPSW
) (
    input  logic                    i_EMU_MCLK,
    input  logic                    i_EMU_INITRST,

    input  logic                    ioctl_upload,
    input  logic [15:0]             ioctl_index,
    input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
    input  logic                    ioctl_rd,
    output logic [7:0]              ioctl_din,
    output logic                    ioctl_wait,

    output logic [AW-1:0]           o_MEM_ADDR,
    output logic                    o_MEM_RD,
    input  logic [7:0]              i_MEM_DATA,

    input  logic [7:0]              i_DIPSW1,
    input  logic [7:0]              i_DIPSW2,

    output logic                    o_UPLOAD_BUSY,
    output logic                    o_UPLOAD_DONE
);

    // Counter only needs to hold RD_LAT-1 (at most 3).
    localparam int CNT_W = 2;

    upload_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_rd_q, mem_rd_d;
    logic [7:0]      din_q, din_d;
    logic            wait_q, wait_d;
    logic            busy_q;
    logic            done_pend_q, done_pend_d;
    logic            done_q, done_d;

    logic            rd_req;
    logic            in_range;
    logic            upload_fall;

    assign rd_req      = ioctl_rd & ioctl_upload;
    // Full-width compare so addresses that alias above 2^AW are rejected.
    assign in_range    = ioctl_addr < IOCTL_ADDR_W'(MEM_SIZE);
    // Registered upload is about to go from 1 to 0 at this edge.
    assign upload_fall = busy_q & ~ioctl_upload;

    // Request decode, fetch sequencing and read-data capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        din_d      = din_q;
        wait_d     = wait_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    if ((ioctl_index == UPLD_INDEX) && in_range) begin
                        mem_addr_d = ioctl_addr[AW-1:0];
                        mem_rd_d   = 1'b1;
                        wait_d     = 1'b1;
                        state_d    = ST_FETCH;
                    end else if (ioctl_index == DIPSW_INDEX) begin
                        if (ioctl_addr == IOCTL_ADDR_W'(0)) begin
                            din_d = i_DIPSW1;
                        end else if (ioctl_addr == IOCTL_ADDR_W'(1)) begin
                            din_d = i_DIPSW2;
                        end else begin
                            din_d = 8'hFF;
                        end
                    end else begin
                        din_d = 8'hFF;
                    end
                end
            end
            ST_FETCH: begin
                // The BRAM strobe was issued on entry; now count its latency.
                cnt_d   = CNT_W'(RD_LAT - 1);
                state_d = (RD_LAT == 1) ? ST_CAPTURE : ST_LAT;
            end
            ST_LAT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                din_d   = i_MEM_DATA;
                wait_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Session-end pulse, held off until the responder is (about to be) idle.
    always_comb begin
        done_pend_d = 1'b0;
        done_d      = 1'b0;
        if (upload_fall || done_pend_q) begin
            if (state_d == ST_IDLE) begin
                done_d = 1'b1;
            end else begin
                done_pend_d = 1'b1;
            end
        end
    end

    // State and output registers; reset abandons any fetch in progress.
    always_ff @(posedge i_EMU_MCLK) begin
        if (i_EMU_INITRST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            din_q       <= 8'hFF;
            wait_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            din_q       <= din_d;
            wait_q      <= wait_d;
            busy_q      <= ioctl_upload;
            done_pend_q <= done_pend_d;
            done_q      <= done_d;
        end
    end

    assign ioctl_din     = din_q;
    assign ioctl_wait    = wait_q;
    assign o_MEM_ADDR    = mem_addr_q;
    assign o_MEM_RD      = mem_rd_q;
    assign o_UPLOAD_BUSY = busy_q;
    assign o_UPLOAD_DONE = done_q;

endmodule

// File: doc/suprloco_ioctl_upload.md
Name: suprloco_ioctl_upload

Overview:
- MiSTer ioctl upload responder: the read-back direction of the ROM/DIP download path.
- The HPS issues ioctl_rd strobes with ioctl_upload high; this block fetches each byte from a synchronous game-board BRAM read port, or from the DIP switch registers, and returns it on ioctl_din.
- ioctl_wait stalls the HPS while a fetch is in flight.
- Sits in the emu layer beside the download logic; used for NVRAM/hiscore save and ROM read-back verification.

Parameters:
- AW, 17, BRAM byte-address width.
- MEM_SIZE, 17'h1A620, valid byte count; addresses >= MEM_SIZE read 8'hFF.
- RD_LAT, 1, BRAM read latency in clocks (1..4).
- UPLD_INDEX, 16'd0, ioctl_index served from BRAM.
- DIPSW_INDEX, 16'd254, ioctl_index served from DIPSW1/DIPSW2.

Ports:
- i_EMU_MCLK  in  1  master clock.
- i_EMU_INITRST  in  1  synchronous active-high reset.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_index  in  16  upload target selector.
- ioctl_addr  in  27  byte address of the current read.
- ioctl_rd  in  1  one-clock read strobe.
- ioctl_din  out  8  returned byte.
- ioctl_wait  out  1  HPS stall.
- o_MEM_ADDR  out  AW  BRAM read address.
- o_MEM_RD  out  1  one-clock BRAM read strobe.
- i_MEM_DATA  in  8  BRAM read data, valid RD_LAT clocks after o_MEM_RD.
- i_DIPSW1  in  8  DIP bank 1.
- i_DIPSW2  in  8  DIP bank 2.
- o_UPLOAD_BUSY  out  1  session active; the core freezes BRAM writers.
- o_UPLOAD_DONE  out  1  one-clock pulse at session end.

Behaviour:
- Reset values:
  - ioctl_din=8'hFF.
  - ioctl_wait=0, o_MEM_RD=0, o_MEM_ADDR=0.
  - o_UPLOAD_BUSY=0, o_UPLOAD_DONE=0.
  - FSM in IDLE.
- Reset is honoured in any state: an in-flight fetch is abandoned, no data is returned, no DONE pulse is generated.
- FSM states: IDLE, FETCH, LAT, CAPTURE.
- IDLE:
  - ioctl_rd=1 and ioctl_upload=1 in cycle 0 -> decode the request.
  - index==UPLD_INDEX and ioctl_addr<MEM_SIZE: latch ioctl_addr[AW-1:0] to o_MEM_ADDR, go to FETCH.
  - index==DIPSW_INDEX: if ioctl_addr==0, ioctl_din<=i_DIPSW1; if ioctl_addr==1, ioctl_din<=i_DIPSW2; any other address, ioctl_din<=8'hFF. Updated in cycle 1; wait never asserted.
  - Any other index, or BRAM address >= MEM_SIZE: ioctl_din<=8'hFF in cycle 1; wait never asserted.
- FETCH (cycle 1):
  - o_MEM_RD=1 for exactly one clock.
  - ioctl_wait=1.
  - Latency counter loaded with RD_LAT-1.
- LAT: decrement the counter; at zero go to CAPTURE. When RD_LAT=1, LAT takes zero cycles and FETCH goes directly to CAPTURE.
- CAPTURE (cycle RD_LAT+1):
  - ioctl_din<=i_MEM_DATA.
  - ioctl_wait<=0, effective at cycle RD_LAT+2.
  - Return to IDLE.
- ioctl_wait is high from cycle 1 through cycle RD_LAT+1 inclusive.
- ioctl_rd while not in IDLE is ignored (protocol violation; no queueing).
- ioctl_rd with ioctl_upload=0 is ignored.
- ioctl_din holds its last value between reads.
- o_UPLOAD_BUSY is ioctl_upload registered once.
- o_UPLOAD_DONE: pulses one clock on the falling edge of registered ioctl_upload, but only once the FSM is in IDLE.
  - If upload drops mid-fetch, the fetch completes normally and DONE pulses the cycle after CAPTURE.
- ioctl_index changing mid-fetch has no effect; the index is decoded only in IDLE.
- Address compare uses the full 27-bit ioctl_addr, so aliasing above 2^AW returns 8'hFF.

Decomposition:
- Shared package suprloco_ioctl_pkg holds:
  - FSM state enum.
  - IOCTL_IDX_ROM=16'd0.
  - IOCTL_IDX_NVRAM=16'd4.
  - IOCTL_IDX_DIPSW=16'd254.
  - ROM_END=17'h1A620.
  The existing download block also imports these constants.
- No sub-module: the latency counter and decode are inline; the block is a single module.

Test Plan:
- BRAM read, RD_LAT=1, index 0, addr 0x00123, model memory returns 8'hA5 -> o_MEM_RD pulses in cycle 1 with o_MEM_ADDR=0x00123; ioctl_wait high in cycles 1–2; ioctl_din=8'hA5 and wait low in cycle 3.
- RD_LAT=3, addr 0x1A61F -> wait high in cycles 1–4; data captured in cycle 5; exactly one o_MEM_RD pulse.
- Out-of-range and unknown-index reads -> ioctl_din=8'hFF in cycle 1, ioctl_wait never rises, o_MEM_RD stays 0:
  - addr 0x1A620 with index 0.
  - any addr with index 7.
- DIP read-back, DIPSW1=8'h40, DIPSW2=8'hF0, index 254 -> addr 0 returns 8'h40, addr 1 returns 8'hF0, addr 2 returns 8'hFF; all without wait.
- Session end: ioctl_upload drops in cycle 2 of an RD_LAT=2 fetch -> data still captured; o_UPLOAD_DONE pulses once, the cycle after CAPTURE; o_UPLOAD_BUSY falls.
- i_EMU_INITRST asserted in cycle 1 of a fetch -> next cycle ioctl_wait=0, ioctl_din=8'hFF, FSM in IDLE, no DONE pulse; a following read succeeds normally.
